area_sequencer: RTL and testbench

- Controller that time-multiplexes one shared multiplier to compute square area, circle area and total area for a sequence of width requests.
- Sits between the 8-bit width counter (upstream, valid/ready) and the result consumer (downstream, valid/ready).
- Computes square = w*w and circle = (COEF*w*w) >> SHIFT in sequence, then their sum.
- Counts completed jobs with a wrapping counter and an overflow pulse.

---
 rtl/area_pkg.sv | 20 ++
 rtl/area_sequencer_if.sv | 39 +++
 rtl/shared_mult.sv | 14 +
 rtl/area_sequencer.sv | 107 ++++++++++
 tb/tb_area_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/area_pkg.sv
// Shared types and default sizing for the area sequencer slice.
package area_pkg;

    localparam int W_DEF     = 8;
    localparam int COEF_DEF  = 201;
    localparam int SHIFT_DEF = 8;

    localparam int W2_DEF    = 2 * W_DEF;
    localparam int W3_DEF    = 3 * W_DEF;
    localparam int WSUM_DEF  = 2 * W_DEF + 1;

    typedef enum logic [2:0] {
        IDLE,
        SQ,
        CIRC,
        SUM,
        DONE
    } state_t;

endpackage

// File: rtl/area_sequencer_if.sv
// Request/result handshake bundle between the width source, the sequencer and the consumer.
interface area_sequencer_if
    import area_pkg::*;
#(
    parameter int W = W_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     width;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   square_area;
    logic [2*W-1:0]   circle_area;
    logic [2*W:0]     total_area;

    modport master (
        output in_valid,
        output width,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  square_area,
        input  circle_area,
        input  total_area
    );

    modport slave (
        input  in_valid,
        input  width,
        input  out_ready,
        output in_ready,
        output out_valid,
        output square_area,
        output circle_area,
        output total_area
    );

endinterface

// File: rtl/shared_mult.sv
// Unsigned 2W x W combinational multiplier, isolated so it can be replaced by a pipelined/DSP block.
module shared_mult
    import area_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [2*W-1:0] a,
    input  logic [W-1:0]   b,
    output logic [3*W-1:0] p
);

    assign p = {{W{1'b0}}, a} * {{(2*W){1'b0}}, b};

endmodule

// File: rtl/area_sequencer.sv
// Sequences square, circle and total area through one shared multiplier per width request.
module area_sequencer
    import area_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int COEF  = COEF_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             Reset,
    area_sequencer_if.slave  bus,
    output logic [7:0]       job_count,
    output logic             cnt_ov,
    output logic             busy
);

    localparam int W2 = 2 * W;
    localparam int W3 = 3 * W;
    localparam logic [W-1:0] COEF_B = W'(COEF);

    state_t          state;
    logic [W-1:0]    w_lat;
    logic [W2-1:0]   mult_a;
    logic [W-1:0]    mult_b;
    logic [W3-1:0]   mult_p;

    // Floor scaling: drop SHIFT fraction bits, keep 2W result bits.
    function automatic logic [W2-1:0] floor_shift(input logic [W3-1:0] p);
        return W2'(p >> SHIFT);
    endfunction

    function automatic logic [W2:0] wide_add(input logic [W2-1:0] x, input logic [W2-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    always_comb begin
        mult_a = '0;
        mult_b = '0;
        case (state)
            SQ: begin
                mult_a = {{W{1'b0}}, w_lat};
                mult_b = w_lat;
            end
            CIRC: begin
                mult_a = bus.square_area;
                mult_b = COEF_B;
            end
            default: ;
        endcase
    end

    shared_mult #(.W(W)) u_mult (
        .a (mult_a),
        .b (mult_b),
        .p (mult_p)
    );

    assign bus.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state           <= IDLE;
            w_lat           <= '0;
            bus.square_area <= '0;
            bus.circle_area <= '0;
            bus.total_area  <= '0;
            bus.out_valid   <= 1'b0;
            job_count       <= '0;
            cnt_ov          <= 1'b0;
        end else begin
            cnt_ov <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        w_lat <= bus.width;
                        state <= SQ;
                    end
                end
                SQ: begin
                    bus.square_area <= mult_p[W2-1:0];
                    state           <= CIRC;
                end
                CIRC: begin
                    bus.circle_area <= floor_shift(mult_p);
                    state           <= SUM;
                end
                SUM: begin
                    bus.total_area <= wide_add(bus.square_area, bus.circle_area);
                    bus.out_valid  <= 1'b1;
                    job_count      <= job_count + 8'd1;
                    cnt_ov         <= (job_count == 8'hFF);
                    state          <= DONE;
                end
                DONE: begin
                    // Results stay frozen until the consumer takes them.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_area_sequencer.sv
// Directed bench for area_sequencer: latency, arithmetic corners, backpressure, reset and count wrap.
module tb_area_sequencer;

    logic       clk = 1'b0;
    logic       Reset;
    logic [7:0] job_count;
    logic       cnt_ov;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_count;
    int         ov_seen = 0;
    logic       ov_mon = 1'b0;

    always #5 clk = ~clk;

    area_sequencer_if #(.W(8)) bus ();

    area_sequencer #(.W(8), .COEF(201), .SHIFT(8)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .bus       (bus),
        .job_count (job_count),
        .cnt_ov    (cnt_ov),
        .busy      (busy)
    );

    always @(negedge clk) if (ov_mon && cnt_ov === 1'b1) ov_seen++;

    // Drive one request at the current negedge; returns at the negedge after the accept edge.
    task automatic accept(input logic [7:0] w);
        bus.in_valid = 1'b1;
        bus.width    = w;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.width    = 8'hA5;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0; bus.in_valid = 1'b0; bus.width = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.square_area, bus.circle_area, bus.total_area} !== '0) begin
            errors++; $display("FAIL reset_results: got %0d/%0d/%0d expected 0/0/0",
                               bus.square_area, bus.circle_area, bus.total_area);
        end
        checks++;
        if ({job_count, cnt_ov, bus.out_valid, busy} !== 11'd0) begin
            errors++; $display("FAIL reset_ctrl: got cnt=%0d ov=%0b ov=%0b busy=%0b expected all 0",
                               job_count, cnt_ov, bus.out_valid, busy);
        end
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: got in_ready=%0b busy=%0b expected 1/0", bus.in_ready, busy);
        end
        exp_count = 8'd0;
    endtask

    task automatic test_single();
        int n;
        bus.out_ready = 1'b1;
        accept(8'd10);
        wait_valid(n);
        exp_count++;
        checks++;
        if (n !== 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", n); end
        checks++;
        if (bus.square_area !== 16'd100 || bus.circle_area !== 16'd78 || bus.total_area !== 17'd178) begin
            errors++; $display("FAIL single_results: got %0d/%0d/%0d expected 100/78/178",
                               bus.square_area, bus.circle_area, bus.total_area);
        end
        checks++;
        if (job_count !== exp_count) begin
            errors++; $display("FAIL single_count: got %0d expected %0d", job_count, exp_count);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL single_return: got out_valid=%0b in_ready=%0b expected 0/1",
                               bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_max();
        int n;
        accept(8'd255);
        wait_valid(n);
        exp_count++;
        checks++;
        if (n !== 3) begin errors++; $display("FAIL max_latency: got %0d expected 3", n); end
        checks++;
        if (bus.square_area !== 16'd65025 || bus.circle_area !== 16'd51054 || bus.total_area !== 17'd116079) begin
            errors++; $display("FAIL max_results: got %0d/%0d/%0d expected 65025/51054/116079",
                               bus.square_area, bus.circle_area, bus.total_area);
        end
        checks++;
        if (job_count !== exp_count) begin
            errors++; $display("FAIL max_count: got %0d expected %0d", job_count, exp_count);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_zero_then_16();
        int n;
        accept(8'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL zero_inready_step%0d: got in_ready=%0b busy=%0b expected 0/1",
                                   i, bus.in_ready, busy);
            end
            if (i < 3) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        exp_count++;
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.square_area, bus.circle_area, bus.total_area} !== '0) begin
            errors++; $display("FAIL zero_results: got valid=%0b %0d/%0d/%0d expected 1 0/0/0",
                               bus.out_valid, bus.square_area, bus.circle_area, bus.total_area);
        end
        @(posedge clk);
        @(negedge clk);
        accept(8'd16);
        wait_valid(n);
        exp_count++;
        checks++;
        if (n !== 3 || bus.square_area !== 16'd256 || bus.circle_area !== 16'd201 || bus.total_area !== 17'd457) begin
            errors++; $display("FAIL w16_results: got lat=%0d %0d/%0d/%0d expected 3 256/201/457",
                               n, bus.square_area, bus.circle_area, bus.total_area);
        end
        checks++;
        if (job_count !== exp_count) begin
            errors++; $display("FAIL w16_count: got %0d expected %0d", job_count, exp_count);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        bus.out_ready = 1'b0;
        accept(8'd10);
        wait_valid(n);
        exp_count++;
        checks++;
        if (n !== 3) begin errors++; $display("FAIL bp_latency: got %0d expected 3", n); end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.width    = 8'd77;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || job_count !== exp_count ||
                bus.square_area !== 16'd100 || bus.circle_area !== 16'd78 || bus.total_area !== 17'd178) begin
                errors++; $display("FAIL bp_hold%0d: got v=%0b r=%0b cnt=%0d %0d/%0d/%0d expected 1 0 %0d 100/78/178",
                                   i, bus.out_valid, bus.in_ready, job_count, bus.square_area,
                                   bus.circle_area, bus.total_area, exp_count);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 || job_count !== exp_count) begin
            errors++; $display("FAIL bp_release: got v=%0b r=%0b busy=%0b cnt=%0d expected 0 1 0 %0d",
                               bus.out_valid, bus.in_ready, busy, job_count, exp_count);
        end
        checks++;
        if (bus.square_area !== 16'd100 || bus.circle_area !== 16'd78 || bus.total_area !== 17'd178) begin
            errors++; $display("FAIL bp_results_held: got %0d/%0d/%0d expected 100/78/178",
                               bus.square_area, bus.circle_area, bus.total_area);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_single_handshake: got v=%0b busy=%0b expected 0/0", bus.out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        accept(8'd10);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || bus.square_area !== 16'd100) begin
            errors++; $display("FAIL mid_pre: got busy=%0b square=%0d expected 1/100", busy, bus.square_area);
        end
        Reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b1;
        exp_count = 8'd0;
        checks++;
        if ({bus.square_area, bus.circle_area, bus.total_area} !== '0 || job_count !== 8'd0 ||
            bus.out_valid !== 1'b0 || cnt_ov !== 1'b0) begin
            errors++; $display("FAIL mid_clear: got %0d/%0d/%0d cnt=%0d v=%0b expected 0/0/0 0 0",
                               bus.square_area, bus.circle_area, bus.total_area, job_count, bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_idle: got in_ready=%0b busy=%0b expected 1/0", bus.in_ready, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_no_valid%0d: got v=%0b busy=%0b expected 0/0", i, bus.out_valid, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.out_ready = 1'b1;
        ov_seen = 0;
        ov_mon  = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            accept(8'd1);
            wait_valid(n);
            exp_count++;
            checks++;
            if (n !== 3 || bus.square_area !== 16'd1 || bus.circle_area !== 16'd0 || bus.total_area !== 17'd1) begin
                errors++; $display("FAIL b2b_job%0d: got lat=%0d %0d/%0d/%0d expected 3 1/0/1",
                                   k, n, bus.square_area, bus.circle_area, bus.total_area);
            end
            checks++;
            if (job_count !== exp_count || cnt_ov !== (k == 256)) begin
                errors++; $display("FAIL b2b_count%0d: got cnt=%0d ov=%0b expected %0d %0b",
                                   k, job_count, cnt_ov, exp_count, (k == 256));
            end
            @(posedge clk);
            @(negedge clk);
        end
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        ov_mon = 1'b0;
        checks++;
        if (ov_seen !== 1) begin errors++; $display("FAIL b2b_ov_pulses: got %0d expected 1", ov_seen); end
        checks++;
        if (job_count !== 8'd0 || cnt_ov !== 1'b0) begin
            errors++; $display("FAIL b2b_wrapped: got cnt=%0d ov=%0b expected 0/0", job_count, cnt_ov);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max();
        test_zero_then_16();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
